// File: rtl/leaf_tx_if.sv
// Handshake and BFT bus bundle between the user/BFT side and the leaf transmit packetizer.
// The master side drives user words, incoming BFT packets and resend; the slave is the packetizer.
interface leaf_tx_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49,
  parameter int CREDIT_BITS  = 8
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
  logic                    resend;
  logic [CREDIT_BITS-1:0]  credits;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    output din_leaf_bft2interface,
    output resend,
    input  ack_interface2user,
    input  dout_leaf_interface2bft,
    input  credits
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  din_leaf_bft2interface,
    input  resend,
    output ack_interface2user,
    output dout_leaf_interface2bft,
    output credits
  );
endinterface

// File: rtl/leaf_tx_packetizer.sv
// Transmit half of a leaf port: wraps user words into BFT data packets under credit flow control,
// replenishes credits from freespace updates, and can replay the last data packet on request.
module leaf_tx_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 3,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int DEST_LEAF             = 0,
  parameter int DEST_PORT             = 0,
  parameter int SELF_LEAF             = 0,
  parameter int SELF_PORT             = 0,
  parameter int INIT_CREDITS          = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic     clk,
  input  logic     reset,
  leaf_tx_if.slave link
);

  localparam int CREDIT_BITS = 8;
  localparam int TYPE_LSB    = PAYLOAD_BITS;
  localparam int ADDR_LSB    = TYPE_LSB + 2;
  localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
  localparam int VLD_BIT     = PACKET_BITS - 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                   state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  hold_q, hold_d;
  logic                     ack_q, ack_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CREDIT_BITS-1:0]   credits_q, credits_d;
  logic [PACKET_BITS-1:0]   last_pkt_q, last_pkt_d;
  logic                     last_vld_q, last_vld_d;

  logic [PACKET_BITS-1:0]   bft;
  logic                     upd_accept;
  logic                     resend_go;
  logic                     send_go;
  logic [PACKET_BITS-1:0]   data_pkt;
  logic [CREDIT_BITS:0]     credit_sum;
  logic                     bft_unused;

  assign bft = link.din_leaf_bft2interface;

  // Only freespace updates addressed to this leaf/port replenish credits.
  assign upd_accept = bft[VLD_BIT]
                   && (bft[TYPE_LSB +: 2] == 2'b01)
                   && (bft[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
                   && (bft[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(SELF_PORT));
  assign bft_unused = ^{bft[ADDR_LSB +: NUM_ADDR_BITS], bft[PAYLOAD_BITS-1:0]};

  assign resend_go = link.resend && last_vld_q;
  assign send_go   = (state_q == FULL) && (credits_q != '0) && !resend_go;

  assign data_pkt = {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT),
                     addr_q, 2'b00, hold_q};

  // One extra bit of headroom so the add can be saturated after the fact.
  assign credit_sum = {1'b0, credits_q}
                    - (CREDIT_BITS+1)'(send_go)
                    + (upd_accept ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    ack_d      = 1'b0;
    dout_d     = '0;
    addr_d     = addr_q;
    last_pkt_d = last_pkt_q;
    last_vld_d = last_vld_q;
    credits_d  = (credit_sum > (CREDIT_BITS+1)'(INIT_CREDITS)) ? CREDIT_BITS'(INIT_CREDITS)
                                                               : credit_sum[CREDIT_BITS-1:0];
    case (state_q)
      EMPTY: begin
        if (link.vld_user2interface) begin
          hold_d  = link.din_leaf_user2interface;
          ack_d   = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (send_go) begin
          state_d    = EMPTY;
          addr_d     = addr_q + 1'b1;
          last_pkt_d = data_pkt;
          last_vld_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (resend_go) begin
      dout_d = last_pkt_q;
    end else if (send_go) begin
      dout_d = data_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      hold_q     <= '0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      addr_q     <= '0;
      credits_q  <= CREDIT_BITS'(INIT_CREDITS);
      last_pkt_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      addr_q     <= addr_d;
      credits_q  <= credits_d;
      last_pkt_q <= last_pkt_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign link.ack_interface2user      = ack_q;
  assign link.dout_leaf_interface2bft = dout_q;
  assign link.credits                 = credits_q;

endmodule
